// File: rtl/process_scheduler.sv
// Time-slice scheduler driving the PC block's slot select, slot-1 load, slot clear and interrupt return; launch-to-user 2 cycles, exit-to-OS 2 cycles.
// halt stalls state and counter without repeating pulses; quantum preemption is built only when SCHED_PREEMPT_EN is defined.
module process_scheduler #(
  parameter int DATA_WIDTH = 32,
  parameter int NPROCESS   = 2,
  parameter int QUANTUM    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  halt,
  input  logic                  launch,
  input  logic [DATA_WIDTH-1:0] startAddr,
  input  logic [DATA_WIDTH-1:0] quantumIn,
  input  logic                  yield,
  input  logic                  processEnd,
  input  logic [DATA_WIDTH-1:0] processPC,
  output logic                  add,
  output logic [DATA_WIDTH-1:0] adressIn,
  output logic                  changePC,
  output logic                  changeSource,
  output logic                  itrr,
  output logic [DATA_WIDTH-1:0] savedPC,
  output logic [1:0]            cause,
  output logic                  busy
);
  // The launched user process always lives in the last PC slot.
  localparam logic USER_SLOT = 1'(NPROCESS - 1);

  typedef enum logic [2:0] {IDLE, LOAD, RUN, SAVE, RETURN} state_t;

  state_t     state;
  logic [1:0] pend_cause;
  logic       expire;

`ifdef SCHED_PREEMPT_EN
  logic [DATA_WIDTH-1:0] quantum_q;
  logic [DATA_WIDTH-1:0] counter;

  assign expire = (counter == DATA_WIDTH'(1));

  // Counter saturates at 1 so a late event can never see it wrap.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      quantum_q <= '0;
      counter   <= '0;
    end else if (!halt) begin
      if (state == IDLE && launch)
        quantum_q <= (quantumIn == '0) ? DATA_WIDTH'(QUANTUM) : quantumIn;
      if (state == LOAD)
        counter <= quantum_q;
      else if (state == RUN && counter > DATA_WIDTH'(1))
        counter <= counter - DATA_WIDTH'(1);
    end
  end
`else
  logic unused_cfg;

  assign expire     = 1'b0;
  assign unused_cfg = ^{quantumIn, QUANTUM[0]};
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      add          <= 1'b0;
      adressIn     <= '0;
      changePC     <= 1'b0;
      changeSource <= 1'b0;
      itrr         <= 1'b0;
      savedPC      <= '0;
      cause        <= 2'd0;
      busy         <= 1'b0;
      pend_cause   <= 2'd0;
    end else if (halt) begin
      // Frozen, but a pulse already shown must not stretch across the stall.
      changePC     <= 1'b0;
      changeSource <= 1'b0;
      itrr         <= 1'b0;
    end else begin
      changePC     <= 1'b0;
      changeSource <= 1'b0;
      itrr         <= 1'b0;
      unique case (state)
        IDLE: begin
          if (launch) begin
            state    <= LOAD;
            adressIn <= startAddr;
            changePC <= 1'b1;
            busy     <= 1'b1;
          end
        end
        LOAD: begin
          state <= RUN;
          add   <= USER_SLOT;
        end
        RUN: begin
          if (processEnd || yield || expire) begin
            state      <= SAVE;
            pend_cause <= processEnd ? 2'd3 : (yield ? 2'd2 : 2'd1);
          end
        end
        SAVE: begin
          state        <= RETURN;
          add          <= 1'b0;
          savedPC      <= processPC;
          cause        <= pend_cause;
          changeSource <= 1'b1;
          itrr         <= 1'b1;
        end
        RETURN: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          add   <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_process_scheduler.sv
`timescale 1ns/1ps
module tb_process_scheduler;
  localparam int DW   = 32;
  localparam int QDEF = 16;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          halt = 1'b0, launch = 1'b0, yield = 1'b0, processEnd = 1'b0;
  logic [DW-1:0] startAddr = '0, quantumIn = '0, processPC = '0;
  logic          add, changePC, changeSource, itrr, busy;
  logic [DW-1:0] adressIn, savedPC;
  logic [1:0]    cause;

  int            total = 0;
  int            bad = 0;
  logic [DW-1:0] exp_saved = '0;
  logic [1:0]    exp_cause = 2'd0;

  wire [4:0] ctl = {add, changePC, changeSource, itrr, busy};

  process_scheduler #(.DATA_WIDTH(DW), .NPROCESS(2), .QUANTUM(QDEF)) dut (
    .clock(clock), .reset(reset), .halt(halt), .launch(launch),
    .startAddr(startAddr), .quantumIn(quantumIn), .yield(yield),
    .processEnd(processEnd), .processPC(processPC), .add(add),
    .adressIn(adressIn), .changePC(changePC), .changeSource(changeSource),
    .itrr(itrr), .savedPC(savedPC), .cause(cause), .busy(busy)
  );

  always #5 clock = ~clock;

  // Unhalted RUN cycles before switch-out: earliest of quantum (preempt build) and events.
  function automatic int exit_after(input int q, input int ey, input int ee);
    int k;
    k = 1 << 30;
`ifdef SCHED_PREEMPT_EN
    k = q;
`endif
    if (ey > 0 && ey < k) k = ey;
    if (ee > 0 && ee < k) k = ee;
    return k;
  endfunction

  // One full job from the IDLE cycle that presents launch to the RETURN cycle.
  task automatic run_job(input logic [DW-1:0] start, input logic [DW-1:0] qin,
                         input int ey_in, input int ee_in, input int halt_at,
                         input int halt_len, input int halt_load, input bit relaunch,
                         input string nm);
    int q, k, ey, ee, ha, u, hleft, run_total;
    logic [1:0] c;
    logic [DW-1:0] spc;
    ey = ey_in;
    ee = ee_in;
    q = (qin == 0) ? QDEF : int'(qin);
`ifndef SCHED_PREEMPT_EN
    if (ey == 0 && ee == 0) ey = q;
`endif
    k = exit_after(q, ey, ee);
    c = (ee == k) ? 2'd3 : ((ey == k) ? 2'd2 : 2'd1);
    ha = (halt_at >= k) ? k - 1 : halt_at;
    run_total = k + halt_len;

    @(negedge clock);
    total++;
    if (ctl !== 5'b00000 || savedPC !== exp_saved || cause !== exp_cause) begin
      bad++;
      $display("FAIL %s idle: ctl=%b saved=%h cause=%0d want ctl=00000 saved=%h cause=%0d",
               nm, ctl, savedPC, cause, exp_saved, exp_cause);
    end
    launch = 1'b1; startAddr = start; quantumIn = qin;

    @(negedge clock);
    launch = 1'b0; startAddr = $urandom; quantumIn = $urandom;
    total++;
    if (ctl !== 5'b01001 || adressIn !== start) begin
      bad++;
      $display("FAIL %s load: ctl=%b addr=%h want ctl=01001 addr=%h", nm, ctl, adressIn, start);
    end
    for (int i = 0; i < halt_load; i++) begin
      halt = 1'b1;
      @(negedge clock);
      total++;
      if (ctl !== 5'b00001 || adressIn !== start) begin
        bad++;
        $display("FAIL %s load_halted: ctl=%b addr=%h want ctl=00001 addr=%h", nm, ctl, adressIn, start);
      end
    end
    halt = 1'b0;

    u = 0;
    hleft = halt_len;
    for (int i = 0; i < run_total; i++) begin
      @(negedge clock);
      total++;
      if (ctl !== 5'b10001 || adressIn !== start) begin
        bad++;
        $display("FAIL %s run cycle %0d: ctl=%b addr=%h want ctl=10001 addr=%h", nm, i, ctl, adressIn, start);
      end
      processPC = $urandom;
      launch = relaunch && (i == 1);
      startAddr = ~start;
      if (u == ha && hleft > 0) begin
        halt = 1'b1; yield = 1'b0; processEnd = 1'b0;
        hleft--;
      end else begin
        halt = 1'b0;
        u++;
        yield = (u == ey);
        processEnd = (u == ee);
      end
    end

    @(negedge clock);
    halt = 1'b0; launch = 1'b0; yield = 1'b0; processEnd = 1'b0;
    total++;
    if (ctl !== 5'b10001 || savedPC !== exp_saved) begin
      bad++;
      $display("FAIL %s save: ctl=%b saved=%h want ctl=10001 saved=%h", nm, ctl, savedPC, exp_saved);
    end
    spc = $urandom;
    processPC = spc;

    @(negedge clock);
    total++;
    if (ctl !== 5'b00111 || savedPC !== spc || cause !== c) begin
      bad++;
      $display("FAIL %s return: ctl=%b saved=%h cause=%0d want ctl=00111 saved=%h cause=%0d",
               nm, ctl, savedPC, cause, spc, c);
    end
    processPC = $urandom;
    exp_saved = spc;
    exp_cause = c;
  endtask

  task automatic test_reset();
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ctl, adressIn, savedPC, cause} !== '0) begin
      bad++;
      $display("FAIL reset_async: ctl=%b addr=%h saved=%h cause=%0d want all zero", ctl, adressIn, savedPC, cause);
    end
    @(negedge clock);
    @(negedge clock);
    total++;
    if ({ctl, adressIn, savedPC, cause} !== '0) begin
      bad++;
      $display("FAIL reset_hold: ctl=%b addr=%h saved=%h cause=%0d want all zero", ctl, adressIn, savedPC, cause);
    end
    reset = 1'b1;
  endtask

  task automatic test_quantum();
    run_job(32'h40, 32'd4, 0, 0, 0, 0, 0, 1'b0, "quantum");
  endtask

  task automatic test_yield();
    run_job(32'h100, 32'd10, 2, 0, 0, 0, 0, 1'b0, "yield");
  endtask

  task automatic test_coincide();
    run_job(32'h200, 32'd4, 4, 4, 0, 0, 0, 1'b0, "coincide");
  endtask

  task automatic test_halt();
    run_job(32'h300, 32'd4, 0, 0, 2, 5, 2, 1'b0, "halt");
  endtask

  task automatic test_default_quantum();
    run_job(32'h400, 32'd0, 0, 0, 0, 0, 0, 1'b1, "default_q");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++)
      run_job(32'h500 + DW'(i), 32'd3, 1, 0, 0, 0, 0, 1'b0, "back_to_back");
  endtask

  task automatic test_random();
    for (int i = 0; i < 25; i++)
      run_job($urandom, DW'($urandom_range(0, 6)), $urandom_range(0, 8), $urandom_range(0, 8),
              $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 1),
              1'($urandom_range(0, 1)), "random");
  endtask

  task automatic test_reset_in_save();
    @(negedge clock);
    launch = 1'b1; startAddr = 32'h80; quantumIn = 32'd8;
    @(negedge clock);
    launch = 1'b0;
    @(negedge clock);
    yield = 1'b1;
    @(negedge clock);
    yield = 1'b0;
    total++;
    if (ctl !== 5'b10001) begin
      bad++;
      $display("FAIL rst_save entry: ctl=%b want 10001", ctl);
    end
    #2 reset = 1'b0;
    #1;
    total++;
    if ({ctl, adressIn, savedPC, cause} !== '0) begin
      bad++;
      $display("FAIL rst_save async: ctl=%b addr=%h saved=%h cause=%0d want all zero", ctl, adressIn, savedPC, cause);
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      total++;
      if (ctl !== 5'b00000) begin
        bad++;
        $display("FAIL rst_save hold %0d: ctl=%b want 00000", i, ctl);
      end
    end
    reset = 1'b1;
    exp_saved = '0;
    exp_cause = 2'd0;
    @(negedge clock);
    total++;
    if (ctl !== 5'b00000 || savedPC !== '0) begin
      bad++;
      $display("FAIL rst_save release: ctl=%b saved=%h want ctl=00000 saved=0", ctl, savedPC);
    end
  endtask

  initial begin
    test_reset();
    test_quantum();
    test_yield();
    test_coincide();
    test_halt();
    test_default_quantum();
    test_back_to_back();
    test_random();
    test_reset_in_save();
    run_job(32'h600, 32'd2, 0, 1, 0, 0, 0, 1'b0, "after_reset");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/process_scheduler.md
# process_scheduler

Time-slice scheduler that drives the context-switch side of the multi-process program counter. It launches a user process at a start address supplied by the OS, then counts its quantum while it runs. On quantum expiry, yield or process end, it saves the user PC and hands control back to the OS process (PID 0) at address 0. It sits beside the program counter and sources that block's `add`, `changePC`, `changeSource` and `itrr` controls.

## Interface
- `DATA_WIDTH`, 32, address/data width
- `NPROCESS`, 2, number of PC slots; slot 0 is the OS, slot 1 is the launched user process
- `QUANTUM`, 16, default time slice in cycles; used when `quantumIn` is 0
- `clock`  in  1  sole clock, rising edge
- `reset`  in  1  asynchronous, active-low reset
- `halt`  in  1  processor halt; freezes scheduler state and counter
- `launch`  in  1  one-cycle OS request to start the user process
- `startAddr`  in  DATA_WIDTH  user process start address, sampled with `launch`
- `quantumIn`  in  DATA_WIDTH  time slice in cycles, sampled with `launch`
- `yield`  in  1  user process voluntary yield (syscall)
- `processEnd`  in  1  user process terminated
- `processPC`  in  DATA_WIDTH  current user PC, read back from PC slot 1
- `add`  out  1  active PC slot select (0 = OS, 1 = user)
- `adressIn`  out  DATA_WIDTH  address loaded into slot 1 when `changePC` is high
- `changePC`  out  1  one-cycle load of slot 1
- `changeSource`  out  1  one-cycle clear of the selected slot to 0
- `itrr`  out  1  one-cycle interrupt-return indication to the OS
- `savedPC`  out  DATA_WIDTH  user PC captured at the last switch-out
- `cause`  out  2  last switch cause: 0 none, 1 quantum, 2 yield, 3 end
- `busy`  out  1  high whenever the FSM is not in IDLE

## Operation
- States and transitions:
  - IDLE: `add`=0, OS runs. `launch` moves to LOAD.
  - LOAD: `changePC`=1, `adressIn`=latched `startAddr`. Loads the counter with `quantumIn`, or with `QUANTUM` when `quantumIn` is 0. Moves to RUN.
  - RUN: `add`=1. The counter decrements each cycle that `halt` is low. Leaves for SAVE on `processEnd`, `yield`, or a counter value of 1 (preempt build only).
  - SAVE: `add`=1. `savedPC`<=`processPC`. `cause` is updated. Moves to RETURN.
  - RETURN: `add`=0, `changeSource`=1, `itrr`=1. The OS restarts at 0. Moves to IDLE.
- Cause priority when events coincide: end (3) > yield (2) > quantum (1).
- `launch` outside IDLE is ignored; no queueing.
- `halt` freezes the state, the counter and all registers. Single-cycle pulse outputs are not repeated while halted.
- The counter is DATA_WIDTH bits, unsigned, and never wraps: it stops at 1.
- Reset values: `add`=0, `adressIn`=0, `changePC`=0, `changeSource`=0, `itrr`=0, `savedPC`=0, `cause`=0, `busy`=0, counter 0, state IDLE.
- Reset in any state aborts immediately to IDLE. No save or return sequence is issued.

## Timing
- All outputs are registered. `changePC`, `changeSource` and `itrr` are exactly one cycle wide.
- `launch` at edge N: LOAD (`changePC`=1) during cycle N+1; `add`=1 from cycle N+2.
- Quantum Q: RUN lasts Q unhalted cycles, then SAVE for 1 cycle, then RETURN for 1 cycle.
- `yield` or `processEnd` sampled in RUN at edge N: SAVE in cycle N+1, RETURN in N+2, IDLE in N+3.
- `savedPC` is valid from the cycle after SAVE and holds until the next SAVE.

## Configuration
- `SCHED_PREEMPT_EN` defined: quantum expiry forces a switch-out with `cause`=1.
- `SCHED_PREEMPT_EN` undefined:
  - The counter and the quantum exit are removed.
  - RUN exits only on `yield` or `processEnd`.
  - `quantumIn` is ignored and `cause` never equals 1.

## Test plan
- Reset, then `launch` with `startAddr`=0x40 and `quantumIn`=4, no events: `changePC` pulses with `adressIn`=0x40; 4 RUN cycles; `savedPC` equals `processPC`; `changeSource`/`itrr` pulse; `cause`=1 (preempt build).
- RUN with `yield` on the second cycle: SAVE, then RETURN on the next two cycles; `cause`=2.
- `yield`, `processEnd` and quantum expiry all in the same cycle: `cause`=3.
- `halt` held 5 cycles mid-RUN with `quantumIn`=4: the switch-out is delayed by exactly 5 cycles, and each pulse output lasts one cycle.
- `quantumIn`=0: RUN lasts `QUANTUM`=16 cycles. A second `launch` during RUN is ignored.
- `reset` asserted in SAVE: all outputs return to reset values asynchronously, and no `changeSource` is issued.
